// File: rtl/elevator_pkg.sv
// Shared state encoding, sweep-direction codes and SCAN helpers for the elevator controller.
package elevator_pkg;

   localparam int MAX_FLOORS = 64;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_MOVE_UP,
      ST_MOVE_DOWN,
      ST_DOOR_OPEN,
      ST_DOOR_HOLD,
      ST_DOOR_CLOSE
   } state_t;

   localparam logic [1:0] DIR_IDLE = 2'b00;
   localparam logic [1:0] DIR_UP   = 2'b01;
   localparam logic [1:0] DIR_DOWN = 2'b10;

   function automatic logic door_is_open(input state_t s);
      return (s == ST_DOOR_OPEN) || (s == ST_DOOR_HOLD);
   endfunction

   // Request vectors are zero-extended to MAX_FLOORS by the caller.
   function automatic logic scan_above(input logic [MAX_FLOORS-1:0] vec, input int cur);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < MAX_FLOORS; i++)
         if ((i > cur) && vec[i]) hit = 1'b1;
      return hit;
   endfunction

   function automatic logic scan_below(input logic [MAX_FLOORS-1:0] vec, input int cur);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < MAX_FLOORS; i++)
         if ((i < cur) && vec[i]) hit = 1'b1;
      return hit;
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/elevator_door_timer.sv
// Loadable down-counter for door phases; zero flags the terminal count.
module elevator_door_timer #(
   parameter int CW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          tick,
   output logic          zero
);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (tick && (cnt != '0))
         cnt <= cnt - 1'b1;
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/elevator_scan_ctrl.sv
// N-floor SCAN elevator controller: request latching, motor command, floor count, door sequencing.
//   state         | meaning
//   ST_IDLE       | car parked, doors shut, waiting for a request
//   ST_MOVE_UP    | motor up, counting arrival pulses
//   ST_MOVE_DOWN  | motor down, counting arrival pulses
//   ST_DOOR_OPEN  | door opening for T_DOOR cycles
//   ST_DOOR_HOLD  | door held open for T_WAIT cycles, restarted by a press at this floor
//   ST_DOOR_CLOSE | door closing for T_CLOSE cycles, re-opens on obstruction/press
module elevator_scan_ctrl
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS = 8,
   parameter int T_DOOR     = 2,
   parameter int T_WAIT     = 4,
   parameter int T_CLOSE    = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_FLOORS-1:0]         req,
   input  logic                          floor_arrived,
   input  logic                          door_obstruct,
   output logic                          move_up,
   output logic                          move_down,
   output logic [$clog2(NUM_FLOORS)-1:0] current_floor,
   output logic [NUM_FLOORS-1:0]         floor_led,
   output logic [1:0]                    direction,
   output logic                          door_open,
   output logic                          door_closing,
   output logic [NUM_FLOORS-1:0]         pending
);

   localparam int FW = $clog2(NUM_FLOORS);
   localparam int CW = $clog2(max3(T_DOOR, T_WAIT, T_CLOSE) + 1);

   localparam logic [FW-1:0] TOP_FLOOR = FW'(NUM_FLOORS - 1);
   // Timer loads T-1 so that a phase lasts exactly T cycles including the entry cycle.
   localparam logic [CW-1:0] LD_DOOR  = CW'(T_DOOR - 1);
   localparam logic [CW-1:0] LD_WAIT  = CW'(T_WAIT - 1);
   localparam logic [CW-1:0] LD_CLOSE = CW'(T_CLOSE - 1);

   state_t                  state;
   state_t                  state_nxt;
   logic [FW-1:0]           floor_nxt;
   logic [1:0]              dir_nxt;
   logic [NUM_FLOORS-1:0]   pend_or_req;
   logic [NUM_FLOORS-1:0]   led_nxt;
   logic [NUM_FLOORS-1:0]   clr;
   logic [MAX_FLOORS-1:0]   pend_ext;
   logic                    above;
   logic                    below;
   logic                    here;
   logic                    t_load;
   logic                    t_tick;
   logic [CW-1:0]           t_val;
   logic                    t_zero;

   elevator_door_timer #(
      .CW (CW)
   ) u_door_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (t_load),
      .load_val (t_val),
      .tick     (t_tick),
      .zero     (t_zero)
   );

   assign pend_or_req = pending | req;
   assign pend_ext    = MAX_FLOORS'(pending);
   assign above       = scan_above(pend_ext, int'(current_floor));
   assign below       = scan_below(pend_ext, int'(current_floor));
   assign here        = pend_or_req[current_floor];

   always_comb begin
      state_nxt = state;
      dir_nxt   = direction;
      floor_nxt = current_floor;
      t_load    = 1'b0;
      t_val     = '0;
      t_tick    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (here) begin
               state_nxt = ST_DOOR_OPEN;
               t_load    = 1'b1;
               t_val     = LD_DOOR;
            end else if (above) begin
               state_nxt = ST_MOVE_UP;
               dir_nxt   = DIR_UP;
            end else if (below) begin
               state_nxt = ST_MOVE_DOWN;
               dir_nxt   = DIR_DOWN;
            end
         end
         ST_MOVE_UP: begin
            if (floor_arrived) begin
               if (current_floor == TOP_FLOOR) begin
                  // Saturate at the shaft end and let IDLE re-decide the sweep.
                  state_nxt = ST_IDLE;
                  dir_nxt   = DIR_IDLE;
               end else begin
                  floor_nxt = current_floor + 1'b1;
                  if (pend_or_req[floor_nxt]) begin
                     state_nxt = ST_DOOR_OPEN;
                     t_load    = 1'b1;
                     t_val     = LD_DOOR;
                  end
               end
            end
         end
         ST_MOVE_DOWN: begin
            if (floor_arrived) begin
               if (current_floor == '0) begin
                  state_nxt = ST_IDLE;
                  dir_nxt   = DIR_IDLE;
               end else begin
                  floor_nxt = current_floor - 1'b1;
                  if (pend_or_req[floor_nxt]) begin
                     state_nxt = ST_DOOR_OPEN;
                     t_load    = 1'b1;
                     t_val     = LD_DOOR;
                  end
               end
            end
         end
         ST_DOOR_OPEN: begin
            t_tick = 1'b1;
            if (t_zero) begin
               state_nxt = ST_DOOR_HOLD;
               t_load    = 1'b1;
               t_val     = LD_WAIT;
            end
         end
         ST_DOOR_HOLD: begin
            t_tick = 1'b1;
            if (req[current_floor]) begin
               t_load = 1'b1;
               t_val  = LD_WAIT;
            end else if (t_zero) begin
               state_nxt = ST_DOOR_CLOSE;
               t_load    = 1'b1;
               t_val     = LD_CLOSE;
            end
         end
         ST_DOOR_CLOSE: begin
            t_tick = 1'b1;
            if (door_obstruct || req[current_floor]) begin
               state_nxt = ST_DOOR_OPEN;
               t_load    = 1'b1;
               t_val     = LD_DOOR;
            end else if (t_zero) begin
               // SCAN: keep the sweep while work lies ahead, otherwise reverse or park.
               if (direction == DIR_DOWN) begin
                  if (below) begin
                     state_nxt = ST_MOVE_DOWN;
                  end else if (above) begin
                     state_nxt = ST_MOVE_UP;
                     dir_nxt   = DIR_UP;
                  end else begin
                     state_nxt = ST_IDLE;
                     dir_nxt   = DIR_IDLE;
                  end
               end else begin
                  if (above) begin
                     state_nxt = ST_MOVE_UP;
                     dir_nxt   = DIR_UP;
                  end else if (below) begin
                     state_nxt = ST_MOVE_DOWN;
                     dir_nxt   = DIR_DOWN;
                  end else begin
                     state_nxt = ST_IDLE;
                     dir_nxt   = DIR_IDLE;
                  end
               end
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            dir_nxt   = DIR_IDLE;
         end
      endcase
   end

   assign led_nxt = NUM_FLOORS'(1) << floor_nxt;
   assign clr     = door_is_open(state_nxt) ? led_nxt : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_nxt;
   end

   // Outputs are decoded from the next state so they line up with the state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         current_floor <= '0;
         floor_led     <= NUM_FLOORS'(1);
         direction     <= DIR_IDLE;
         pending       <= '0;
         move_up       <= 1'b0;
         move_down     <= 1'b0;
         door_open     <= 1'b0;
         door_closing  <= 1'b0;
      end else begin
         current_floor <= floor_nxt;
         floor_led     <= led_nxt;
         direction     <= dir_nxt;
         pending       <= pend_or_req & ~clr;
         move_up       <= (state_nxt == ST_MOVE_UP);
         move_down     <= (state_nxt == ST_MOVE_DOWN);
         door_open     <= door_is_open(state_nxt);
         door_closing  <= (state_nxt == ST_DOOR_CLOSE);
      end
   end

endmodule
